// File: rtl/bin_to_7seg_mux_if.sv
// Bundle between the value source and the seven-segment display driver.
// The value source holds the master modport and the display driver holds the slave modport.
interface bin_to_7seg_mux_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] bin_val;
    logic             load;
    logic             hex_mode;
    logic             blank_lz;
    logic             busy;
    logic             ovf;
    logic [6:0]       seg;
    logic [7:0]       an;
    logic             dp;

    modport master (
        output bin_val, load, hex_mode, blank_lz,
        input  busy, ovf, seg, an, dp
    );

    modport slave (
        input  bin_val, load, hex_mode, blank_lz,
        output busy, ovf, seg, an, dp
    );
endinterface

// File: rtl/bin_to_7seg_mux.sv
// Binary/hex to multiplexed common-anode seven-segment driver.
// The decimal path is a sequential double-dabble conversion with a sticky overflow flag.
module bin_to_7seg_mux #(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    bin_to_7seg_mux_if.slave    bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DIGITS - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               hex_q, hex_d;
    logic [WIDTH-1:0]   shr_q, shr_d;
    logic [BW-1:0]      work_q, work_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic [RW-1:0]      ref_q, ref_d;
    logic [2:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [7:0]         an_q, an_d;
    logic               dp_q, dp_d;

    logic [BW-1:0]       adj_s;
    logic [BW+WIDTH-1:0] ext_s;
    logic [BW-1:0]       nib_sh_s;
    logic [DIGITS-1:0]   zero_from_s;
    logic [DIGITS-1:0]   zf_sh_s;
    logic                zero_up_s;
    logic                lz_hit_s;

    function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] w);
        logic [BW-1:0] r;
        r = w;
        for (int k = 0; k < DIGITS; k++) begin
            if (w[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = w[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = w[4*k +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Conversion FSM: capture on load, iterate double-dabble or copy hex, publish result.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        hex_d   = hex_q;
        shr_d   = shr_q;
        work_d  = work_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        adj_s   = dabble_adj(work_q);
        ext_s   = {{BW{1'b0}}, shr_q};
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d = CONV;
                    busy_d  = 1'b1;
                    hex_d   = bus.hex_mode;
                    shr_d   = bus.bin_val;
                    work_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            CONV: begin
                if (hex_q) begin
                    disp_d  = ext_s[BW-1:0];
                    ovf_d   = |ext_s[BW+WIDTH-1:BW];
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // The top-nibble MSB shifted out is the only evidence the value exceeds the digit count.
                    work_d  = {adj_s[BW-2:0], shr_q[WIDTH-1]};
                    shr_d   = {shr_q[WIDTH-2:0], 1'b0};
                    carry_d = carry_q | adj_s[BW-1];
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        disp_d  = {adj_s[BW-2:0], shr_q[WIDTH-1]};
                        ovf_d   = carry_q | adj_s[BW-1];
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Refresh timer and digit index, free-running regardless of conversions.
    always_comb begin
        ref_d = ref_q;
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            ref_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            ref_d = ref_q + RW'(1);
        end
    end

    // Segment/anode pattern for the selected digit, including dash and blanking rules.
    always_comb begin
        zero_up_s = 1'b1;
        zero_from_s = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_up_s = zero_up_s & (disp_q[4*k +: 4] == 4'd0);
            zero_from_s[k] = zero_up_s;
        end
        nib_sh_s = disp_q >> {idx_q, 2'b00};
        zf_sh_s  = zero_from_s >> idx_q;
        lz_hit_s = bus.blank_lz & zf_sh_s[0] & (idx_q != 3'd0);
        if (ovf_q) begin
            seg_d = 7'b0111111;
        end else if (lz_hit_s) begin
            seg_d = 7'b1111111;
        end else begin
            seg_d = seg_decode(nib_sh_s[3:0]);
        end
        an_d = ~(8'd1 << idx_q);
        dp_d = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            hex_q   <= 1'b0;
            shr_q   <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            ref_q   <= '0;
            idx_q   <= 3'd0;
            seg_q   <= 7'b1000000;
            an_q    <= 8'hFE;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            hex_q   <= hex_d;
            shr_q   <= shr_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.ovf  = ovf_q;
    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = dp_q;
endmodule

// File: tb/tb_bin_to_7seg_mux.sv
// Directed bench for bin_to_7seg_mux: three instances (8, 4 and 2 digits) with a fast refresh.
module tb_bin_to_7seg_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_7seg_mux_if #(.WIDTH(16)) if8 ();
    bin_to_7seg_mux_if #(.WIDTH(16)) if4 ();
    bin_to_7seg_mux_if #(.WIDTH(16)) if2 ();

    bin_to_7seg_mux #(.WIDTH(16), .DIGITS(8), .REFRESH_DIV(4)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    bin_to_7seg_mux #(.WIDTH(16), .DIGITS(4), .REFRESH_DIV(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    bin_to_7seg_mux #(.WIDTH(16), .DIGITS(2), .REFRESH_DIV(4)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b0000011, SE = 7'b0000110, SF = 7'b0001110;
    localparam logic [6:0] SDASH = 7'b0111111, SBLK = 7'b1111111;

    int cmp = 0;
    int err = 0;

    task automatic get_out(input int inst, output logic [7:0] a, output logic [6:0] s,
                           output logic b, output logic o, output logic d);
        case (inst)
            0:       begin a = if8.an; s = if8.seg; b = if8.busy; o = if8.ovf; d = if8.dp; end
            1:       begin a = if4.an; s = if4.seg; b = if4.busy; o = if4.ovf; d = if4.dp; end
            default: begin a = if2.an; s = if2.seg; b = if2.busy; o = if2.ovf; d = if2.dp; end
        endcase
    endtask

    task automatic drive_load(input int inst, input logic [15:0] v, input logic hx);
        @(negedge clk);
        case (inst)
            0:       begin if8.bin_val = v; if8.hex_mode = hx; if8.load = 1'b1; end
            1:       begin if4.bin_val = v; if4.hex_mode = hx; if4.load = 1'b1; end
            default: begin if2.bin_val = v; if2.hex_mode = hx; if2.load = 1'b1; end
        endcase
        @(negedge clk);
        if8.load = 1'b0;
        if4.load = 1'b0;
        if2.load = 1'b0;
    endtask

    // Counts sampled cycles with busy high, bounded at 100.
    task automatic count_busy(input int inst, output int n);
        logic [7:0] a; logic [6:0] s; logic b, o, d;
        n = 0;
        get_out(inst, a, s, b, o, d);
        while (b && n < 100) begin
            n++;
            @(negedge clk);
            get_out(inst, a, s, b, o, d);
        end
    endtask

    // Waits (bounded) for digit k's anode and returns the segments shown with it.
    task automatic find_digit(input int inst, input int k, output logic [6:0] seg_o, output bit ok);
        logic [7:0] a; logic [6:0] s; logic b, o, d;
        logic [7:0] want;
        want = ~(8'd1 << k);
        ok = 1'b0;
        seg_o = 7'bx;
        for (int i = 0; i < 80 && !ok; i++) begin
            get_out(inst, a, s, b, o, d);
            if (a === want) begin
                ok = 1'b1;
                seg_o = s;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] a; logic [6:0] s; logic b, o, d;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 get_out(0, a, s, b, o, d);
        cmp++; if (a !== 8'hFE) begin err++; $display("FAIL reset_an: got %h want fe", a); end
        cmp++; if (s !== S0) begin err++; $display("FAIL reset_seg: got %b want %b", s, S0); end
        cmp++; if (b !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", b); end
        cmp++; if (o !== 1'b0) begin err++; $display("FAIL reset_ovf: got %b want 0", o); end
        cmp++; if (d !== 1'b1) begin err++; $display("FAIL reset_dp: got %b want 1", d); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decimal_blank();
        logic [6:0] exp8 [8];
        logic [6:0] s; bit ok; int n;
        logic [7:0] a; logic b, o, d;
        exp8 = '{S4, S3, S2, S1, SBLK, SBLK, SBLK, SBLK};
        if8.blank_lz = 1'b1;
        drive_load(0, 16'd1234, 1'b0);
        count_busy(0, n);
        cmp++; if (n != 16) begin err++; $display("FAIL dec_busy_len: got %0d want 16", n); end
        @(negedge clk);
        get_out(0, a, s, b, o, d);
        cmp++; if (o !== 1'b0) begin err++; $display("FAIL dec_ovf: got %b want 0", o); end
        for (int k = 0; k < 8; k++) begin
            find_digit(0, k, s, ok);
            cmp++;
            if (!ok || s !== exp8[k]) begin
                err++; $display("FAIL dec1234_digit%0d: got %b want %b found=%0d", k, s, exp8[k], ok);
            end
        end
    endtask

    task automatic test_refresh();
        logic [7:0] a; logic [6:0] s; logic b, o, d;
        int n; bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            get_out(0, a, s, b, o, d);
            if (a === 8'hFB) ok = 1'b1;
            else @(negedge clk);
        end
        n = 0;
        get_out(0, a, s, b, o, d);
        while (a === 8'hFB && n < 20) begin
            n++;
            @(negedge clk);
            get_out(0, a, s, b, o, d);
        end
        cmp++;
        if (!ok || n != 4) begin err++; $display("FAIL refresh_hold: got %0d want 4 found=%0d", n, ok); end
    endtask

    task automatic test_load_ignored();
        logic [6:0] exp8 [8];
        logic [6:0] s; bit ok; int n;
        exp8 = '{S4, S3, S2, S1, SBLK, SBLK, SBLK, SBLK};
        drive_load(0, 16'd5, 1'b0);
        count_busy(0, n);
        drive_load(0, 16'd1234, 1'b0);
        repeat (3) @(negedge clk);
        drive_load(0, 16'd9, 1'b0);
        count_busy(0, n);
        cmp++; if (n != 11) begin err++; $display("FAIL ign_busy_rem: got %0d want 11", n); end
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            find_digit(0, k, s, ok);
            cmp++;
            if (!ok || s !== exp8[k]) begin
                err++; $display("FAIL ign_digit%0d: got %b want %b found=%0d", k, s, exp8[k], ok);
            end
        end
        if8.blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 4; k < 8; k++) begin
            find_digit(0, k, s, ok);
            cmp++;
            if (!ok || s !== S0) begin err++; $display("FAIL noblank_digit%0d: got %b want %b", k, s, S0); end
        end
    endtask

    task automatic test_ovf_d4();
        logic [7:0] a; logic [6:0] s; logic b, o, d;
        bit ok; int n; bit an_hi_ok;
        if4.blank_lz = 1'b1;
        drive_load(1, 16'd9999, 1'b0);
        count_busy(1, n);
        cmp++; if (n != 16) begin err++; $display("FAIL d4_busy_len: got %0d want 16", n); end
        @(negedge clk);
        get_out(1, a, s, b, o, d);
        cmp++; if (o !== 1'b0) begin err++; $display("FAIL d4_9999_ovf: got %b want 0", o); end
        for (int k = 0; k < 4; k++) begin
            find_digit(1, k, s, ok);
            cmp++;
            if (!ok || s !== S9) begin err++; $display("FAIL d4_9999_digit%0d: got %b want %b", k, s, S9); end
        end
        drive_load(1, 16'd10000, 1'b0);
        count_busy(1, n);
        @(negedge clk);
        get_out(1, a, s, b, o, d);
        cmp++; if (o !== 1'b1) begin err++; $display("FAIL d4_10000_ovf: got %b want 1", o); end
        for (int k = 0; k < 4; k++) begin
            find_digit(1, k, s, ok);
            cmp++;
            if (!ok || s !== SDASH) begin err++; $display("FAIL d4_10000_digit%0d: got %b want %b", k, s, SDASH); end
        end
        an_hi_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            get_out(1, a, s, b, o, d);
            if (a[7:4] !== 4'hF) an_hi_ok = 1'b0;
            @(negedge clk);
        end
        cmp++; if (!an_hi_ok) begin err++; $display("FAIL d4_an_upper: got low bit, want 4'hf"); end
    endtask

    task automatic test_hex();
        logic [6:0] exp8 [8];
        logic [7:0] a; logic [6:0] s; logic b, o, d;
        bit ok; int n;
        exp8 = '{SF, SE, SE, SB, SBLK, SBLK, SBLK, SBLK};
        if8.blank_lz = 1'b1;
        drive_load(0, 16'hBEEF, 1'b1);
        count_busy(0, n);
        cmp++; if (n != 1) begin err++; $display("FAIL hex_busy_len: got %0d want 1", n); end
        @(negedge clk);
        get_out(0, a, s, b, o, d);
        cmp++; if (o !== 1'b0) begin err++; $display("FAIL hex_ovf: got %b want 0", o); end
        for (int k = 0; k < 8; k++) begin
            find_digit(0, k, s, ok);
            cmp++;
            if (!ok || s !== exp8[k]) begin err++; $display("FAIL hex_digit%0d: got %b want %b", k, s, exp8[k]); end
        end
        if2.blank_lz = 1'b0;
        drive_load(2, 16'h0100, 1'b1);
        count_busy(2, n);
        @(negedge clk);
        get_out(2, a, s, b, o, d);
        cmp++; if (o !== 1'b1) begin err++; $display("FAIL d2_hex_ovf: got %b want 1", o); end
        for (int k = 0; k < 2; k++) begin
            find_digit(2, k, s, ok);
            cmp++;
            if (!ok || s !== SDASH) begin err++; $display("FAIL d2_hex_digit%0d: got %b want %b", k, s, SDASH); end
        end
    endtask

    task automatic test_reset_midconv();
        logic [6:0] exp8 [8];
        logic [7:0] a; logic [6:0] s; logic b, o, d;
        bit ok; int n;
        exp8 = '{S5, S3, S5, S5, S6, SBLK, SBLK, SBLK};
        if8.blank_lz = 1'b1;
        drive_load(0, 16'd65535, 1'b0);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 get_out(0, a, s, b, o, d);
        cmp++; if (b !== 1'b0) begin err++; $display("FAIL midrst_busy: got %b want 0", b); end
        cmp++; if (a !== 8'hFE) begin err++; $display("FAIL midrst_an: got %h want fe", a); end
        cmp++; if (s !== S0) begin err++; $display("FAIL midrst_seg: got %b want %b", s, S0); end
        get_out(1, a, s, b, o, d);
        cmp++; if (o !== 1'b0) begin err++; $display("FAIL midrst_d4_ovf: got %b want 0", o); end
        get_out(2, a, s, b, o, d);
        cmp++; if (o !== 1'b0) begin err++; $display("FAIL midrst_d2_ovf: got %b want 0", o); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        get_out(0, a, s, b, o, d);
        cmp++; if (b !== 1'b0) begin err++; $display("FAIL midrst_no_resume: got %b want 0", b); end
        drive_load(0, 16'd65535, 1'b0);
        count_busy(0, n);
        cmp++; if (n != 16) begin err++; $display("FAIL post_busy_len: got %0d want 16", n); end
        @(negedge clk);
        get_out(0, a, s, b, o, d);
        cmp++; if (o !== 1'b0) begin err++; $display("FAIL post_ovf: got %b want 0", o); end
        for (int k = 0; k < 8; k++) begin
            find_digit(0, k, s, ok);
            cmp++;
            if (!ok || s !== exp8[k]) begin err++; $display("FAIL post65535_digit%0d: got %b want %b", k, s, exp8[k]); end
        end
    endtask

    initial begin
        if8.bin_val = 16'd0; if8.load = 1'b0; if8.hex_mode = 1'b0; if8.blank_lz = 1'b0;
        if4.bin_val = 16'd0; if4.load = 1'b0; if4.hex_mode = 1'b0; if4.blank_lz = 1'b0;
        if2.bin_val = 16'd0; if2.load = 1'b0; if2.hex_mode = 1'b0; if2.blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_decimal_blank();
        test_refresh();
        test_load_ignored();
        test_ovf_d4();
        test_hex();
        test_reset_midconv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
